pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 21 ++
 rtl/pc_sequencer_if.sv | 49 ++++
 rtl/pc_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer.
// Holds the PC width, interrupt vector, FSM state type and a PC+1 helper.
package pc_sequencer_pkg;

    localparam int unsigned PC_W = 12;

    localparam logic [PC_W-1:0] IRQ_VECTOR = 12'h004;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        UPDATE
    } state_t;

    // Sequential successor of a PC; wraps 12'hFFF to 12'h000.
    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the PC sequencer (master) and fetch/exec/PC logic (slave).
// Carries fetch handshake, exec result, halt, PC register controls and,
// with PC_SEQUENCER_IRQ_EN defined, irq/reti/irq_ack.
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic            fetch_req;
    logic            fetch_ack;
    logic            exec_done;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            halt;
    logic [PC_W-1:0] pc_q;
    logic            pc_hold;
    logic            pc_increment;
    logic            pc_load;
    logic [PC_W-1:0] pc_d;

`ifdef PC_SEQUENCER_IRQ_EN
    logic            irq;
    logic            reti;
    logic            irq_ack;

    modport master (
        output fetch_req, pc_hold, pc_increment, pc_load, pc_d, irq_ack,
        input  fetch_ack, exec_done, branch_taken, branch_target,
        input  halt, pc_q, irq, reti
    );

    modport slave (
        input  fetch_req, pc_hold, pc_increment, pc_load, pc_d, irq_ack,
        output fetch_ack, exec_done, branch_taken, branch_target,
        output halt, pc_q, irq, reti
    );
`else
    modport master (
        output fetch_req, pc_hold, pc_increment, pc_load, pc_d,
        input  fetch_ack, exec_done, branch_taken, branch_target,
        input  halt, pc_q
    );

    modport slave (
        input  fetch_req, pc_hold, pc_increment, pc_load, pc_d,
        output fetch_ack, exec_done, branch_taken, branch_target,
        output halt, pc_q
    );
`endif

endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: IDLE -> FETCH -> EXEC -> UPDATE -> FETCH control loop.
// Ports: clk, rst_n (async, active-low), sif (pc_sequencer_if.master).
// Optional PC_SEQUENCER_IRQ_EN adds irq entry / reti return via epc.
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.master sif
);

    state_t          state;
    logic            fetch_req_q;
    logic            br_q;
    logic [PC_W-1:0] tgt_q;
    logic            upd;
    logic            inc_c;
    logic            load_c;
    logic [PC_W-1:0] d_c;

    // An UPDATE cycle only takes effect while not halted.
    assign upd = (state == UPDATE) && !sif.halt;

`ifdef PC_SEQUENCER_IRQ_EN
    logic            reti_q;
    logic            in_irq;
    logic [PC_W-1:0] epc;
    logic [PC_W-1:0] ret_pc;
    logic            take_irq;
    logic            ack_c;

    // Address the interrupted flow would have continued at.
    assign ret_pc   = br_q ? tgt_q : pc_next(sif.pc_q);
    // A pending reti owns this UPDATE; the irq waits for the next one.
    assign take_irq = sif.irq && !in_irq && !reti_q;
`else
    logic unused_pc;
    assign unused_pc = ^sif.pc_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_req_q <= 1'b0;
            br_q        <= 1'b0;
            tgt_q       <= '0;
`ifdef PC_SEQUENCER_IRQ_EN
            reti_q      <= 1'b0;
            in_irq      <= 1'b0;
            epc         <= '0;
`endif
        end else if (!sif.halt) begin
            unique case (state)
                IDLE: begin
                    state       <= FETCH;
                    fetch_req_q <= 1'b1;
                end
                FETCH: begin
                    if (sif.fetch_ack) begin
                        state       <= EXEC;
                        fetch_req_q <= 1'b0;
                    end
                end
                EXEC: begin
                    if (sif.exec_done) begin
                        state  <= UPDATE;
                        br_q   <= sif.branch_taken;
                        tgt_q  <= sif.branch_target;
`ifdef PC_SEQUENCER_IRQ_EN
                        reti_q <= sif.reti;
`endif
                    end
                end
                UPDATE: begin
                    state       <= FETCH;
                    fetch_req_q <= 1'b1;
                    br_q        <= 1'b0;
                    tgt_q       <= '0;
`ifdef PC_SEQUENCER_IRQ_EN
                    reti_q      <= 1'b0;
                    if (reti_q) begin
                        in_irq <= 1'b0;
                    end else if (take_irq) begin
                        epc    <= ret_pc;
                        in_irq <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        inc_c  = 1'b0;
        load_c = 1'b0;
        d_c    = '0;
`ifdef PC_SEQUENCER_IRQ_EN
        ack_c  = 1'b0;
        if (upd) begin
            if (reti_q) begin
                load_c = 1'b1;
                d_c    = epc;
            end else if (take_irq) begin
                load_c = 1'b1;
                d_c    = IRQ_VECTOR;
                ack_c  = 1'b1;
            end else if (br_q) begin
                load_c = 1'b1;
                d_c    = tgt_q;
            end else begin
                inc_c  = 1'b1;
            end
        end
`else
        if (upd) begin
            if (br_q) begin
                load_c = 1'b1;
                d_c    = tgt_q;
            end else begin
                inc_c  = 1'b1;
            end
        end
`endif
    end

    // Halt takes effect in the same cycle it is raised.
    assign sif.fetch_req    = fetch_req_q & ~sif.halt;
    assign sif.pc_hold      = sif.halt & rst_n;
    assign sif.pc_increment = inc_c;
    assign sif.pc_load      = load_c;
    assign sif.pc_d         = d_c;
`ifdef PC_SEQUENCER_IRQ_EN
    assign sif.irq_ack      = ack_c;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with a model PC register.
// IRQ checks are compiled in when PC_SEQUENCER_IRQ_EN is defined.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic clk;
    logic rst_n;
    logic [PC_W-1:0] pc;
    int n_cmp;
    int n_bad;
    int fr_cnt;
    int inc_cnt;
    int fr_base;
    int inc_base;

    pc_sequencer_if sif();

    pc_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External PC register driven by the sequencer controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= '0;
        else if (sif.pc_load)
            pc <= sif.pc_d;
        else if (sif.pc_increment)
            pc <= pc + 12'd1;
    end
    assign sif.pc_q = pc;

    always @(negedge clk) begin
        if (sif.fetch_req)    fr_cnt  <= fr_cnt + 1;
        if (sif.pc_increment) inc_cnt <= inc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // From FETCH: ack, then exec_done with the given branch; ends
    // mid-way through the UPDATE cycle with inputs cleared.
    task automatic to_update(input logic br, input logic [11:0] tgt);
        sif.fetch_ack = 1'b1;
        tick;
        sif.fetch_ack     = 1'b0;
        sif.exec_done     = 1'b1;
        sif.branch_taken  = br;
        sif.branch_target = tgt;
        tick;
        sif.exec_done     = 1'b0;
        sif.branch_taken  = 1'b0;
        sif.branch_target = '0;
        #3;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        fr_cnt  = 0;
        inc_cnt = 0;
        rst_n   = 1'b0;
        sif.fetch_ack     = 1'b0;
        sif.exec_done     = 1'b0;
        sif.branch_taken  = 1'b0;
        sif.branch_target = '0;
        sif.halt          = 1'b0;
`ifdef PC_SEQUENCER_IRQ_EN
        sif.irq  = 1'b0;
        sif.reti = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        sif.halt = 1'b1;
        #3;
        chk("rst_hold", sif.pc_hold, 0);
        chk("rst_freq", sif.fetch_req, 0);
        chk("rst_inc", sif.pc_increment, 0);
        chk("rst_load", sif.pc_load, 0);
        chk("rst_pcd", sif.pc_d, 0);
        sif.halt = 1'b0;

        // Basic fetch/exec/increment loop.
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("idle_freq", sif.fetch_req, 0);
        fr_base  = fr_cnt;
        inc_base = inc_cnt;
        tick;
        #3;
        chk("fetch_freq", sif.fetch_req, 1);
        tick;
        tick;
        sif.fetch_ack = 1'b1;
        tick;
        #3;
        chk("freq_drop", sif.fetch_req, 0);
        chk("freq_cycles", fr_cnt - fr_base, 3);
        tick;
        sif.fetch_ack = 1'b0;
        sif.exec_done = 1'b1;
        #3;
        chk("exec_wait_inc", sif.pc_increment, 0);
        tick;
        sif.exec_done = 1'b0;
        #3;
        chk("upd_inc", sif.pc_increment, 1);
        chk("upd_noload", sif.pc_load, 0);
        chk("upd_pcd0", sif.pc_d, 0);
        chk("upd_pc_old", pc, 0);
        tick;
        #3;
        chk("pc_one", pc, 1);
        chk("back_fetch", sif.fetch_req, 1);
        chk("inc_off", sif.pc_increment, 0);
        chk("inc_pulses", inc_cnt - inc_base, 1);

        // Branch; stray exec_done during FETCH is ignored.
        sif.exec_done = 1'b1;
        sif.fetch_ack = 1'b1;
        tick;
        sif.exec_done = 1'b0;
        sif.fetch_ack = 1'b0;
        #3;
        chk("stray_done_inc", sif.pc_increment, 0);
        chk("stray_done_load", sif.pc_load, 0);
        tick;
        sif.exec_done     = 1'b1;
        sif.branch_taken  = 1'b1;
        sif.branch_target = 12'h3A5;
        tick;
        sif.exec_done     = 1'b0;
        sif.branch_taken  = 1'b0;
        sif.branch_target = '0;
        #3;
        chk("br_load", sif.pc_load, 1);
        chk("br_pcd", sif.pc_d, 12'h3A5);
        chk("br_noinc", sif.pc_increment, 0);
        tick;
        #3;
        chk("br_pc", pc, 12'h3A5);
        chk("br_load_off", sif.pc_load, 0);
        chk("br_pcd_off", sif.pc_d, 0);

        // Halt in FETCH: request drops, ack is not sampled.
        sif.halt      = 1'b1;
        sif.fetch_ack = 1'b1;
        #3;
        chk("hf_freq", sif.fetch_req, 0);
        chk("hf_hold", sif.pc_hold, 1);
        tick;
        sif.halt      = 1'b0;
        sif.fetch_ack = 1'b0;
        #3;
        chk("hf_resume", sif.fetch_req, 1);

        // Halt across an UPDATE for 4 cycles.
        inc_base = inc_cnt;
        sif.fetch_ack = 1'b1;
        tick;
        sif.fetch_ack = 1'b0;
        sif.exec_done = 1'b1;
        tick;
        sif.exec_done = 1'b0;
        sif.halt      = 1'b1;
        #3;
        chk("hu_hold", sif.pc_hold, 1);
        chk("hu_inc", sif.pc_increment, 0);
        chk("hu_load", sif.pc_load, 0);
        chk("hu_freq", sif.fetch_req, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            #3;
            chk("hu_inc_n", sif.pc_increment, 0);
            chk("hu_hold_n", sif.pc_hold, 1);
        end
        tick;
        sif.halt = 1'b0;
        #3;
        chk("hu_rel_inc", sif.pc_increment, 1);
        chk("hu_rel_hold", sif.pc_hold, 0);
        chk("hu_pc_kept", pc, 12'h3A5);
        tick;
        #3;
        chk("hu_pc_next", pc, 12'h3A6);
        chk("hu_inc_off", sif.pc_increment, 0);
        chk("hu_pulses", inc_cnt - inc_base, 1);

        // Reset during EXEC; late exec_done after release is ignored.
        sif.fetch_ack = 1'b1;
        tick;
        sif.fetch_ack = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("rx_freq", sif.fetch_req, 0);
        chk("rx_inc", sif.pc_increment, 0);
        chk("rx_load", sif.pc_load, 0);
        chk("rx_pc", pc, 0);
        tick;
        rst_n = 1'b1;
        sif.exec_done = 1'b1;
        #3;
        chk("rx_idle_freq", sif.fetch_req, 0);
        chk("rx_idle_inc", sif.pc_increment, 0);
        tick;
        sif.exec_done = 1'b0;
        #3;
        chk("rx_fetch_freq", sif.fetch_req, 1);
        chk("rx_fetch_inc", sif.pc_increment, 0);
        chk("rx_fetch_load", sif.pc_load, 0);
        sif.fetch_ack = 1'b1;
        tick;
        sif.fetch_ack = 1'b0;
        #3;
        chk("rx_exec_inc", sif.pc_increment, 0);
        tick;
        #3;
        chk("rx_exec_wait", sif.pc_increment, 0);

        // Jump to the top of the address space.
        sif.exec_done     = 1'b1;
        sif.branch_taken  = 1'b1;
        sif.branch_target = 12'hFFF;
        tick;
        sif.exec_done     = 1'b0;
        sif.branch_taken  = 1'b0;
        sif.branch_target = '0;
        #3;
        chk("top_pcd", sif.pc_d, 12'hFFF);
        tick;
        #3;
        chk("top_pc", pc, 12'hFFF);

`ifdef PC_SEQUENCER_IRQ_EN
        sif.irq = 1'b1;
        to_update(1'b0, 12'h000);
        chk("irq_load", sif.pc_load, 1);
        chk("irq_pcd", sif.pc_d, 12'h004);
        chk("irq_ack", sif.irq_ack, 1);
        chk("irq_noinc", sif.pc_increment, 0);
        tick;
        #3;
        chk("irq_pc", pc, 12'h004);
        chk("irq_ack_off", sif.irq_ack, 0);
        to_update(1'b0, 12'h000);
        chk("irq2_ack", sif.irq_ack, 0);
        chk("irq2_inc", sif.pc_increment, 1);
        tick;
        sif.reti = 1'b1;
        to_update(1'b1, 12'h123);
        sif.reti = 1'b0;
        chk("reti_load", sif.pc_load, 1);
        chk("reti_pcd", sif.pc_d, 12'h000);
        chk("reti_ack", sif.irq_ack, 0);
        tick;
        #3;
        chk("reti_pc", pc, 12'h000);
        to_update(1'b0, 12'h000);
        chk("irq3_ack", sif.irq_ack, 1);
        chk("irq3_pcd", sif.pc_d, 12'h004);
        tick;
        sif.irq  = 1'b0;
        sif.reti = 1'b1;
        to_update(1'b0, 12'h000);
        sif.reti = 1'b0;
        chk("reti2_pcd", sif.pc_d, 12'h001);
        chk("reti2_load", sif.pc_load, 1);
        tick;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
